// File: rtl/sap_pkg.sv
// Shared constants for the SAP-style microcomputer: widths, control-word
// bit positions and opcode values used by both datapath and controller.
package sap_pkg;

    localparam int SAP_DATA_W    = 8;
    localparam int SAP_ADDR_W    = 4;
    localparam int SAP_CW_W      = 15;
    localparam int SAP_RAM_DEPTH = 1 << SAP_ADDR_W;

    // Control-word bit positions, MSB (HLT) down to LSB (J).
    localparam int CW_HLT = 14;
    localparam int CW_MI  = 13;
    localparam int CW_RI  = 12;
    localparam int CW_RO  = 11;
    localparam int CW_IO  = 10;
    localparam int CW_II  = 9;
    localparam int CW_AI  = 8;
    localparam int CW_AO  = 7;
    localparam int CW_SO  = 6;
    localparam int CW_SU  = 5;
    localparam int CW_BI  = 4;
    localparam int CW_OI  = 3;
    localparam int CW_CE  = 2;
    localparam int CW_CO  = 1;
    localparam int CW_J   = 0;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_JMP = 4'h4,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // True when two or more of the bus-driver enables are asserted together.
    function automatic logic more_than_one(input logic [4:0] v);
        return (v & (v - 5'd1)) != 5'd0;
    endfunction

endpackage

// File: rtl/sap_ram16x8.sv
// 16x8 program/data RAM: combinational read, synchronous write. The write
// port is taken by the program loader while prog_mode is high, otherwise by
// the datapath's RI path. Contents are never cleared.
module sap_ram16x8
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W
) (
    input  logic              clk,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              run_we,
    input  logic [ADDR_W-1:0] run_addr,
    input  logic [DATA_W-1:0] run_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Select which port owns the single physical write port.
    always_comb begin
        wr_en   = run_we;
        wr_addr = run_addr;
        wr_data = run_data;
        if (prog_mode) begin
            wr_en   = prog_we;
            wr_addr = prog_addr;
            wr_data = prog_data;
        end
    end

    // Synchronous write; no reset so the loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read so RO data is usable in the same cycle as MAR.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sap_datapath.sv
// SAP datapath: PC, MAR, RAM, IR, A/B, add/sub ALU and output register on
// one shared 8-bit bus. Executes the control word present at each rising
// edge and hands the opcode back to the controller.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int CW_W   = SAP_CW_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW_W-1:0]   ctrl_wrd,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] out_data,
    output logic              halt,
    output logic              carry,
    output logic              zero,
    output logic              bus_conflict,
    output logic [DATA_W-1:0] bus_dbg,
    output logic [ADDR_W-1:0] pc_dbg
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              halt_q, halt_d;
    logic              conflict_q, conflict_d;

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_sum;
    logic              active;
    logic              run_we;

    logic cw_hlt, cw_mi, cw_ri, cw_ro, cw_io, cw_ii, cw_ai, cw_ao;
    logic cw_so, cw_su, cw_bi, cw_oi, cw_ce, cw_co, cw_j;

    assign cw_hlt = ctrl_wrd[CW_HLT];
    assign cw_mi  = ctrl_wrd[CW_MI];
    assign cw_ri  = ctrl_wrd[CW_RI];
    assign cw_ro  = ctrl_wrd[CW_RO];
    assign cw_io  = ctrl_wrd[CW_IO];
    assign cw_ii  = ctrl_wrd[CW_II];
    assign cw_ai  = ctrl_wrd[CW_AI];
    assign cw_ao  = ctrl_wrd[CW_AO];
    assign cw_so  = ctrl_wrd[CW_SO];
    assign cw_su  = ctrl_wrd[CW_SU];
    assign cw_bi  = ctrl_wrd[CW_BI];
    assign cw_oi  = ctrl_wrd[CW_OI];
    assign cw_ce  = ctrl_wrd[CW_CE];
    assign cw_co  = ctrl_wrd[CW_CO];
    assign cw_j   = ctrl_wrd[CW_J];

    // The control word only acts while running; halt and program-load freeze it.
    assign active = !halt_q && !prog_mode;
    // Keep RI from writing RAM on an edge that arrives while reset is held.
    assign run_we = active && cw_ri && rst_n;

    sap_ram16x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .prog_mode (prog_mode),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .run_we    (run_we),
        .run_addr  (mar_q),
        .run_data  (bus),
        .rd_addr   (mar_q),
        .rd_data   (ram_rd)
    );

    // ALU: subtraction is A + ~B + 1, so carry=1 means no borrow.
    always_comb begin
        alu_b   = cw_su ? ~b_q : b_q;
        alu_sum = {1'b0, a_q} + {1'b0, alu_b} + (DATA_W + 1)'(cw_su);
    end

    // Shared bus with fixed driver priority RO > IO > AO > SO > CO.
    always_comb begin
        bus = '0;
        if (cw_ro) begin
            bus = ram_rd;
        end else if (cw_io) begin
            bus = {{(DATA_W - 4){1'b0}}, ir_q[3:0]};
        end else if (cw_ao) begin
            bus = a_q;
        end else if (cw_so) begin
            bus = alu_sum[DATA_W-1:0];
        end else if (cw_co) begin
            bus = {{(DATA_W - ADDR_W){1'b0}}, pc_q};
        end
    end

    // Next-state for every register: hold by default, load from the bus when active.
    always_comb begin
        pc_d       = pc_q;
        mar_d      = mar_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        out_d      = out_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        halt_d     = halt_q;
        conflict_d = conflict_q;
        if (active) begin
            if (cw_mi) mar_d = bus[ADDR_W-1:0];
            if (cw_ii) ir_d  = bus;
            if (cw_ai) a_d   = bus;
            if (cw_bi) b_d   = bus;
            if (cw_oi) out_d = bus;
            // A jump wins over the increment when both are in one word.
            if (cw_j) begin
                pc_d = bus[ADDR_W-1:0];
            end else if (cw_ce) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            // Flags track only an ALU result written back into A.
            if (cw_so && cw_ai) begin
                carry_d = alu_sum[DATA_W];
                zero_d  = (alu_sum[DATA_W-1:0] == '0);
            end
            if (cw_hlt) halt_d = 1'b1;
            if (more_than_one({cw_ro, cw_io, cw_ao, cw_so, cw_co})) begin
                conflict_d = 1'b1;
            end
        end
    end

    // Register bank with asynchronous clear; RAM is deliberately not touched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            mar_q      <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            out_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            halt_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            out_q      <= out_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            halt_q     <= halt_d;
            conflict_q <= conflict_d;
        end
    end

    assign opcode       = ir_q[DATA_W-1:DATA_W-4];
    assign out_data     = out_q;
    assign halt         = halt_q;
    assign carry        = carry_q;
    assign zero         = zero_q;
    assign bus_conflict = conflict_q;
    assign bus_dbg      = bus;
    assign pc_dbg       = pc_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Scoreboard bench for sap_datapath: a behavioural machine model predicts
// every observable output; a monitor compares them mid-cycle.
module tb_sap_datapath;
    import sap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] ctrl_wrd = '0;
    logic        prog_mode = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic [3:0]  opcode;
    logic [7:0]  out_data;
    logic        halt, carry, zero, bus_conflict;
    logic [7:0]  bus_dbg;
    logic [3:0]  pc_dbg;

    sap_datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_wrd     (ctrl_wrd),
        .prog_mode    (prog_mode),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .opcode       (opcode),
        .out_data     (out_data),
        .halt         (halt),
        .carry        (carry),
        .zero         (zero),
        .bus_conflict (bus_conflict),
        .bus_dbg      (bus_dbg),
        .pc_dbg       (pc_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] HLT = 15'(1) << CW_HLT;
    localparam logic [14:0] MI  = 15'(1) << CW_MI;
    localparam logic [14:0] RI  = 15'(1) << CW_RI;
    localparam logic [14:0] RO  = 15'(1) << CW_RO;
    localparam logic [14:0] IO  = 15'(1) << CW_IO;
    localparam logic [14:0] II  = 15'(1) << CW_II;
    localparam logic [14:0] AI  = 15'(1) << CW_AI;
    localparam logic [14:0] AO  = 15'(1) << CW_AO;
    localparam logic [14:0] SO  = 15'(1) << CW_SO;
    localparam logic [14:0] SU  = 15'(1) << CW_SU;
    localparam logic [14:0] BI  = 15'(1) << CW_BI;
    localparam logic [14:0] OI  = 15'(1) << CW_OI;
    localparam logic [14:0] CE  = 15'(1) << CW_CE;
    localparam logic [14:0] CO  = 15'(1) << CW_CO;
    localparam logic [14:0] J   = 15'(1) << CW_J;

    typedef struct {
        int         idx;
        int         sel;
        logic [7:0] exp;
        int         tag;
    } chk_t;

    chk_t sbq[$];
    int   mon_idx  = 0;
    int   n_checks = 0;
    int   n_errs   = 0;
    int   step_no  = 0;

    // Reference machine state (plain integers).
    int m_ram [16];
    int m_pc, m_mar, m_ir, m_a, m_b, m_out;
    int m_c, m_z, m_h, m_conf;

    function automatic string sel_name(input int s);
        case (s)
            0: return "opcode";
            1: return "out_data";
            2: return "halt";
            3: return "carry";
            4: return "zero";
            5: return "bus_conflict";
            6: return "bus_dbg";
            default: return "pc_dbg";
        endcase
    endfunction

    function automatic int alu_val(input bit su);
        if (su) return (m_a - m_b + 256) % 256;
        return (m_a + m_b) % 256;
    endfunction

    function automatic int alu_cy(input bit su);
        if (su) return (m_a >= m_b) ? 1 : 0;
        return (m_a + m_b > 255) ? 1 : 0;
    endfunction

    function automatic int m_bus(input logic [14:0] w);
        if (w[CW_RO]) return m_ram[m_mar];
        if (w[CW_IO]) return m_ir % 16;
        if (w[CW_AO]) return m_a;
        if (w[CW_SO]) return alu_val(w[CW_SU]);
        if (w[CW_CO]) return m_pc;
        return 0;
    endfunction

    task automatic m_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
        m_c = 0; m_z = 0; m_h = 0; m_conf = 0;
    endtask

    task automatic push(input int sel, input int val);
        chk_t c;
        c.idx = mon_idx + 1;
        c.sel = sel;
        c.exp = 8'(val);
        c.tag = step_no;
        sbq.push_back(c);
    endtask

    task automatic push_state();
        push(0, m_ir / 16);
        push(1, m_out);
        push(2, m_h);
        push(3, m_c);
        push(4, m_z);
        push(5, m_conf);
        push(7, m_pc);
    endtask

    // One rising edge of the machine as described by its rules.
    task automatic m_exec(input logic [14:0] w, input bit pm, input bit we,
                          input int addr, input int data);
        int b, drivers, mar0;
        if (pm) begin
            if (we) m_ram[addr] = data;
            return;
        end
        if (m_h != 0) return;
        b = m_bus(w);
        mar0 = m_mar;
        drivers = int'(w[CW_RO]) + int'(w[CW_IO]) + int'(w[CW_AO]) + int'(w[CW_SO]) + int'(w[CW_CO]);
        if (drivers > 1) m_conf = 1;
        if (w[CW_SO] && w[CW_AI]) begin
            m_c = alu_cy(w[CW_SU]);
            m_z = (alu_val(w[CW_SU]) == 0) ? 1 : 0;
        end
        if (w[CW_RI]) m_ram[mar0] = b;
        if (w[CW_MI]) m_mar = b % 16;
        if (w[CW_II]) m_ir = b;
        if (w[CW_AI]) m_a = b;
        if (w[CW_BI]) m_b = b;
        if (w[CW_OI]) m_out = b;
        if (w[CW_J]) m_pc = b % 16;
        else if (w[CW_CE]) m_pc = (m_pc + 1) % 16;
        if (w[CW_HLT]) m_h = 1;
    endtask

    // Drive one word half a cycle ahead of the edge, queue the expected view.
    task automatic step(input logic [14:0] w, input bit pm = 1'b0, input bit we = 1'b0,
                        input int addr = 0, input int data = 0);
        @(negedge clk);
        #1;
        ctrl_wrd  = w;
        prog_mode = pm;
        prog_we   = we;
        prog_addr = 4'(addr);
        prog_data = 8'(data);
        step_no++;
        $display("step %0d word=%04h pm=%0d we=%0d addr=%0d data=%02h", step_no, w, pm, we, addr, data);
        push_state();
        if (!pm) push(6, m_bus(w));
        m_exec(w, pm, we, addr, data);
    endtask

    task automatic load(input int addr, input int data);
        step(15'($urandom), 1'b1, 1'b1, addr, data);
    endtask

    // Reset asserted between clock edges; its effect must be visible at once.
    task automatic reset_mid();
        @(negedge clk);
        #2;
        ctrl_wrd  = '0;
        prog_mode = 1'b0;
        prog_we   = 1'b0;
        rst_n     = 1'b0;
        step_no++;
        $display("step %0d async reset", step_no);
        m_reset();
        push_state();
        push(6, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Minimal controller: fetch then microcode by the model's opcode.
    task automatic run_instr();
        step(CO | MI);
        step(RO | II | CE);
        case (m_ir / 16)
            1:  begin step(IO | MI); step(RO | AI); end
            2:  begin step(IO | MI); step(RO | BI); step(SO | AI); end
            3:  begin step(IO | MI); step(RO | BI); step(SO | SU | AI); end
            4:  step(IO | J);
            14: step(AO | OI);
            15: step(HLT);
            default: step('0);
        endcase
    endtask

    // Monitor: sample mid-cycle, after inputs settle and before the next edge.
    initial begin
        forever begin
            logic [7:0] act;
            chk_t c;
            @(negedge clk);
            #3;
            mon_idx++;
            while (sbq.size() > 0 && sbq[0].idx == mon_idx) begin
                c = sbq.pop_front();
                case (c.sel)
                    0: act = {4'h0, opcode};
                    1: act = out_data;
                    2: act = {7'h0, halt};
                    3: act = {7'h0, carry};
                    4: act = {7'h0, zero};
                    5: act = {7'h0, bus_conflict};
                    6: act = bus_dbg;
                    default: act = {4'h0, pc_dbg};
                endcase
                n_checks++;
                if (act !== c.exp) begin
                    n_errs++;
                    $display("FAIL %s step %0d: got %02h expected %02h", sel_name(c.sel), c.tag, act, c.exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int prog [16];
        m_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 0;
        #12;
        rst_n = 1'b1;

        // Reset state with an idle word.
        step('0);

        // Demo program: LDA 14, ADD 15, OUT, HLT.
        for (int i = 0; i < 16; i++) prog[i] = int'($urandom_range(0, 255));
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'h1C; prog[15] = 8'h0E;
        for (int i = 0; i < 16; i++) load(i, prog[i]);
        for (int i = 0; i < 4; i++) run_instr();
        step('0);
        // Halted: a further AI must not change A.
        step(RO | AI);
        step(AO);

        // SUB borrow case.
        reset_mid();
        load(0, 8'h1E); load(1, 8'h3F); load(14, 8'h05); load(15, 8'h07);
        run_instr(); run_instr();
        step(AO);
        // SUB equal case.
        reset_mid();
        load(14, 8'h07);
        run_instr(); run_instr();
        step(AO);

        // JMP beats CE; PC wraps 15 -> 0.
        reset_mid();
        load(0, 8'h49);
        step(CO | MI);
        step(RO | II | CE);
        step(J | IO | CE);
        while (m_pc != 15) step(CE);
        step(CE);
        step('0);

        // Bus conflict with A=0x33, sticky until reset.
        load(m_mar, 8'h33);
        step(RO | AI);
        step(AO | CO);
        for (int i = 0; i < 3; i++) step(CE);

        // Reset in the middle of ADD after BI.
        reset_mid();
        load(0, 8'h1E); load(1, 8'h2F);
        load(14, int'($urandom_range(1, 255))); load(15, int'($urandom_range(1, 255)));
        run_instr();
        step(CO | MI);
        step(RO | II | CE);
        step(IO | MI);
        step(RO | BI);
        reset_mid();
        step(AO);
        step(SO);
        step(RO);

        // Randomized control words and program-mode interleaving.
        for (int r = 0; r < 4; r++) begin
            reset_mid();
            for (int i = 0; i < 16; i++) load(i, int'($urandom_range(0, 255)));
            for (int k = 0; k < 60; k++) begin
                if ($urandom_range(0, 7) == 0)
                    step(15'($urandom), 1'b1, 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
                else
                    step(15'($urandom) & ~HLT);
            end
            step(HLT | (15'($urandom) & ~HLT));
            step(15'($urandom) & ~HLT);
            step(AO);
        end

        step('0);
        step('0);
        repeat (3) @(negedge clk);
        #4;
        n_checks++;
        if (sbq.size() != 0) begin
            n_errs++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
